demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Parametrised, registered 1:N demultiplexer with a valid/ready handshake on the input and on every output channel.
- Each input beat goes to one output channel. The channel comes from an explicit select (addressed mode) or from an internal round-robin pointer (rotate mode).
- The block is the sensor-event fan-out stage in the visitor-counter datapath. It steers entry/exit events to per-direction counters and display paths.

Parameters:
- DATA_W, 8, width of one data beat.
- NUM_CH, 4, number of output channels (2..16; need not be a power of two).
- SEL_W, $clog2(NUM_CH), select/pointer width (derived; do not override).
- ERR_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_W  input beat.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept the beat this cycle.
- sel  in  SEL_W  target channel in addressed mode; sampled with the beat.
- mode  in  1  0 = addressed, 1 = round-robin; sampled with the beat.
- out_data  out  NUM_CH*DATA_W  per-channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  NUM_CH  per-channel beat present.
- out_ready  in  NUM_CH  per-channel downstream ready.
- rr_ptr  out  SEL_W  current round-robin pointer.
- drop_cnt  out  ERR_W  count of beats dropped for an out-of-range select; saturates.

Behaviour:
- Reset (rst_n low, asynchronous): all out_valid=0, all out_data=0, rr_ptr=0, drop_cnt=0. Outputs hold these values while reset is asserted.
- In-flight beats are discarded on reset. No beat is issued after reset release until a new accept occurs.
- Each channel has one output register (valid bit + DATA_W data).
- Target channel tgt = (mode ? rr_ptr : sel).
- Slot free: free[k] = !out_valid[k] | out_ready[k]. The register drains and refills in the same cycle, so full throughput is 1 beat/cycle per channel.
- Handshake:
  - in_ready = (tgt >= NUM_CH) | free[tgt]. It is combinational from sel, mode, rr_ptr, out_valid and out_ready.
  - Accept occurs when in_valid & in_ready.
  - The upstream side holds in_data/sel/mode stable while in_valid & !in_ready.
- Accept with tgt < NUM_CH: next cycle out_valid[tgt]=1 and out_data[tgt]=in_data. Latency is exactly 1 cycle.
- Output hold: a channel with out_valid=1 and out_ready=0 holds its data unchanged.
- Output drain: when out_valid[k] & out_ready[k] and channel k is not refilled this cycle, out_valid[k] drops to 0 next cycle. out_data[k] retains its last value.
- Out-of-range select: accept with tgt >= NUM_CH (addressed mode only, non-power-of-two NUM_CH) drops the beat.
  - No channel is written.
  - drop_cnt increments by 1 and saturates at 2^ERR_W-1 (no wrap).
- Round-robin pointer:
  - rr_ptr advances only on an accepted beat in mode=1.
  - It wraps from NUM_CH-1 to 0.
  - It is never altered by addressed-mode traffic.
- Stall: a blocked round-robin target stalls input. There is no skipping to a free channel, so ordering stays strictly rotational.
- Simultaneous events: a channel that drains and is targeted by an accept in the same cycle takes the new beat, and out_valid stays 1.
- Mode may change beat-to-beat with no bubble.
- Non-target channels are unaffected by any accept.
- No combinational path exists from in_valid to out_valid. A path exists from out_ready to in_ready (documented; upstream must not loop it back).

Decomposition:
- Shared package demux_pkg holds:
  - the MODE_ADDR=1'b0 and MODE_RR=1'b1 constants;
  - a function computing the round-robin next pointer with wrap.
- Sub-module demux_slot is one channel output register: valid/data/ready, load, drain. It is instantiated NUM_CH times in a generate loop.
- The top level holds target decode, in_ready mux, rr_ptr and drop_cnt.

Test Plan:
- Addressed fan-out: NUM_CH=4, all out_ready=1; send 0xA0..0xA3 with sel=0..3 on consecutive cycles → each out_data[k]=0xA0+k with out_valid[k]=1 exactly one cycle after its accept; in_ready stays 1.
- Back-pressure: out_ready[2]=0; send 0x11 then 0x22 to sel=2 → 0x11 held on ch2, in_ready=0 for the second beat until out_ready[2]=1; then 0x22 appears next cycle, no loss, no duplicate.
- Round-robin wrap: mode=1, six beats 0x01..0x06 → channels 0,1,2,3,0,1 in order; rr_ptr ends at 2; addressed beats interleaved do not move rr_ptr.
- Out-of-range drop: NUM_CH=3, sel=3, 300 beats → no out_valid; in_ready=1; drop_cnt saturates at 255 (ERR_W=8).
- Async reset mid-stream: assert rst_n low between clock edges while ch1 is full and rr_ptr=3 → immediately out_valid=0, out_data=0, rr_ptr=0, drop_cnt=0; first post-reset round-robin beat lands on ch0.
- Drain+refill same cycle: ch0 valid with out_ready[0]=1 and new beat 0x55 to ch0 → out_valid[0] stays 1 and out_data[0]=0x55 next cycle; sustained 1 beat/cycle for 16 cycles.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_router fan-out stage.
package demux_pkg;
    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Next round-robin pointer, wrapping at the channel count (which need not be a power of two).
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction
endpackage

// File: rtl/demux_router_if.sv
// Handshake bundle for demux_router: one upstream input channel, NUM_CH downstream channels.
interface demux_router_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic [DATA_W-1:0]        in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         sel;
    logic                     mode;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready;

    modport master (output in_data, in_valid, sel, mode, out_ready,
                    input  in_ready, out_data, out_valid);
    modport slave  (input  in_data, in_valid, sel, mode, out_ready,
                    output in_ready, out_data, out_valid);
endinterface

// File: rtl/demux_slot.sv
// One output channel register: loads on accept, drains on downstream ready.
module demux_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              free
);
    // Free when empty or draining this cycle, so a drain and refill can share a cycle.
    assign free = !valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/demux_router.sv
// Registered 1:N demultiplexer steering sensor events by explicit select or round-robin.
module demux_router
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    demux_router_if.slave    bus,
    output logic [SEL_W-1:0] rr_ptr,
    output logic [ERR_W-1:0] drop_cnt
);
    logic [SEL_W-1:0]                tgt;
    logic                            in_range;
    logic                            tgt_free;
    logic                            accept;
    logic [NUM_CH-1:0]               free;
    logic [NUM_CH-1:0]               load;
    logic [NUM_CH-1:0]               slot_valid;
    logic [NUM_CH-1:0][DATA_W-1:0]   slot_data;

    assign tgt      = (bus.mode == MODE_RR) ? rr_ptr : bus.sel;
    assign in_range = (int'(tgt) < NUM_CH);

    // Out-of-range targets never match a slot, so tgt_free stays 0 and in_ready relies on !in_range.
    always_comb begin
        tgt_free = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (int'(tgt) == k) tgt_free = free[k];
    end

    assign bus.in_ready = !in_range | tgt_free;
    assign accept       = bus.in_valid & bus.in_ready;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
            assign load[k] = accept & in_range & (int'(tgt) == k);
            demux_slot #(.DATA_W(DATA_W)) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .load      (load[k]),
                .load_data (bus.in_data),
                .ready     (bus.out_ready[k]),
                .valid     (slot_valid[k]),
                .data      (slot_data[k]),
                .free      (free[k])
            );
        end
    endgenerate

    assign bus.out_valid = slot_valid;
    assign bus.out_data  = slot_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept && bus.mode == MODE_RR)
                rr_ptr <= SEL_W'(rr_next(32'(rr_ptr), NUM_CH));
            if (accept && !in_range && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench: stimulus pushes expected beats per channel, a negedge monitor pops on handshake.
module tb_demux_router;
    import demux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_router_if #(.DATA_W(8), .NUM_CH(4)) bus4 ();
    demux_router_if #(.DATA_W(8), .NUM_CH(3)) bus3 ();
    logic [1:0] rr4, rr3;
    logic [7:0] drop4, drop3;

    demux_router #(.DATA_W(8), .NUM_CH(4), .ERR_W(8)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .rr_ptr(rr4), .drop_cnt(drop4));
    demux_router #(.DATA_W(8), .NUM_CH(3), .ERR_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3), .rr_ptr(rr3), .drop_cnt(drop3));

    typedef struct {
        logic [7:0] d;
        int         due;
        bit         strict;
    } exp_t;

    exp_t       q [4][$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] model_rr = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] d4(input int k);
        return bus4.out_data[k*8 +: 8];
    endfunction

    // Monitor: every downstream handshake must match the oldest expected beat of that channel.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (bus4.out_valid[k] && bus4.out_ready[k]) begin
                    if (q[k].size() == 0) begin
                        chk($sformatf("ch%0d unexpected beat", k), {56'd0, d4(k)}, 64'hFFFF);
                    end else begin
                        exp_t e;
                        e = q[k].pop_front();
                        chk($sformatf("ch%0d data", k), d4(k), e.d);
                        if (e.strict) chk($sformatf("ch%0d latency cycle", k), cyc, e.due);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic m,
                        input bit exp_rdy, input bit strict);
        int   n;
        int   ch;
        exp_t e;
        bus4.in_data  = d;
        bus4.sel      = s;
        bus4.mode     = m;
        bus4.in_valid = 1'b1;
        @(negedge clk); #1;
        chk($sformatf("in_ready at offer of %0h", d), bus4.in_ready, exp_rdy);
        n = 0;
        while (!bus4.in_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bus4.in_ready) begin
            chk("in_ready wait timeout", 0, 1);
            bus4.in_valid = 1'b0;
            return;
        end
        ch = (m == MODE_RR) ? int'(model_rr) : int'(s);
        e.d = d; e.due = cyc + 1; e.strict = strict;
        q[ch].push_back(e);
        if (m == MODE_RR) model_rr = (model_rr == 2'd3) ? 2'd0 : model_rr + 2'd1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus4.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.sel = '0; bus4.mode = MODE_ADDR;
        bus4.out_ready = '1;
        bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.sel = '0; bus3.mode = MODE_ADDR;
        bus3.out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", bus4.out_valid, 4'h0);
        chk("reset out_data", bus4.out_data, 32'h0);
        chk("reset rr_ptr", rr4, 2'd0);
        chk("reset drop_cnt", drop4, 8'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Addressed fan-out, one beat per cycle
        for (int k = 0; k < 4; k++) send(8'hA0 + 8'(k), 2'(k), MODE_ADDR, 1'b1, 1'b1);
        idle(3);

        // Back-pressure on channel 2
        bus4.out_ready[2] = 1'b0;
        send(8'h11, 2'd2, MODE_ADDR, 1'b1, 1'b0);
        fork
            send(8'h22, 2'd2, MODE_ADDR, 1'b0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk); #2;
                    chk("ch2 held valid", bus4.out_valid[2], 1'b1);
                    chk("ch2 held data", d4(2), 8'h11);
                end
                @(posedge clk); #1;
                bus4.out_ready[2] = 1'b1;
            end
        join
        idle(3);

        // Round-robin with interleaved addressed beats
        send(8'h01, 2'd0, MODE_RR, 1'b1, 1'b1);
        send(8'h02, 2'd0, MODE_RR, 1'b1, 1'b1);
        send(8'h70, 2'd3, MODE_ADDR, 1'b1, 1'b1);
        chk("rr_ptr after addressed beat", rr4, 2'd2);
        send(8'h03, 2'd0, MODE_RR, 1'b1, 1'b1);
        send(8'h04, 2'd0, MODE_RR, 1'b1, 1'b1);
        send(8'h71, 2'd1, MODE_ADDR, 1'b1, 1'b1);
        chk("rr_ptr after wrap", rr4, 2'd0);
        send(8'h05, 2'd0, MODE_RR, 1'b1, 1'b1);
        send(8'h06, 2'd0, MODE_RR, 1'b1, 1'b1);
        idle(2);
        chk("rr_ptr after six rr beats", rr4, 2'd2);

        // Out-of-range drops on the 3-channel instance
        bus3.sel = 2'd3; bus3.mode = MODE_ADDR; bus3.in_data = 8'hEE; bus3.in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            chk("u3 in_ready on drop", bus3.in_ready, 1'b1);
            chk("u3 no out_valid on drop", bus3.out_valid, 3'b000);
            chk($sformatf("u3 drop_cnt at %0d", i), drop3, (i > 255) ? 8'd255 : 8'(i));
        end
        @(posedge clk); #1;
        bus3.sel = 2'd2; bus3.in_data = 8'h5A;
        @(posedge clk); #1;
        bus3.in_valid = 1'b0;
        chk("u3 drop_cnt saturated", drop3, 8'd255);
        chk("u3 in-range beat valid", bus3.out_valid, 3'b100);
        chk("u3 in-range beat data", bus3.out_data[23:16], 8'h5A);
        chk("u4 drop_cnt untouched", drop4, 8'd0);

        // Async reset mid-stream with ch1 full and rr_ptr at 3
        bus4.out_ready[1] = 1'b0;
        send(8'h07, 2'd0, MODE_RR, 1'b1, 1'b1);
        send(8'h33, 2'd1, MODE_ADDR, 1'b1, 1'b0);
        idle(2);
        chk("pre-reset rr_ptr", rr4, 2'd3);
        chk("pre-reset ch1 full", bus4.out_valid[1], 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) q[k].delete();
        model_rr = 2'd0;
        #1;
        chk("async reset out_valid", bus4.out_valid, 4'h0);
        chk("async reset out_data", bus4.out_data, 32'h0);
        chk("async reset rr_ptr", rr4, 2'd0);
        chk("async reset u3 drop_cnt", drop3, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("held reset out_valid", bus4.out_valid, 4'h0);
        @(negedge clk) rst_n = 1'b1;
        bus4.out_ready = '1;
        idle(3);
        send(8'h88, 2'd2, MODE_RR, 1'b1, 1'b1);
        idle(2);
        chk("rr_ptr after post-reset beat", rr4, 2'd1);

        // Drain and refill channel 0 every cycle
        send(8'h54, 2'd0, MODE_ADDR, 1'b1, 1'b1);
        send(8'h55, 2'd0, MODE_ADDR, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) send(8'h60 + 8'(i), 2'd0, MODE_ADDR, 1'b1, 1'b1);
        idle(3);

        for (int k = 0; k < 4; k++) chk($sformatf("ch%0d pending beats at end", k), q[k].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
